regfile_mp_fwd: RTL



---
 rtl/regfile_mp_fwd.sv | 65 ++++++
 1 files changed

// File: rtl/regfile_mp_fwd.sv
// regfile_mp_fwd: multi-port register file with write-first bypass and a pending-write scoreboard
module regfile_mp_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_WR-1:0]          we,
    input  logic [N_WR*ADDR_W-1:0]   w_addr,
    input  logic [N_WR*DATA_W-1:0]   w_data,
    input  logic [N_RD*ADDR_W-1:0]   r_addr,
    output logic [N_RD*DATA_W-1:0]   r_data,
    output logic [N_RD-1:0]          r_busy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // false only for the hardwired zero register
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    // ascending k so the youngest port's assignment lands last; set follows clear so set wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            for (int k = 0; k < N_WR; k++)
                if (we[k] && live(w_addr[k*ADDR_W +: ADDR_W])) begin
                    regs[w_addr[k*ADDR_W +: ADDR_W]] <= w_data[k*DATA_W +: DATA_W];
                    busy[w_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            if (sb_set && live(sb_addr))
                busy[sb_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              hit;
        assign a = r_addr[i*ADDR_W +: ADDR_W];
        always_comb begin
            d   = regs[a];
            hit = 1'b0;
            for (int k = 0; k < N_WR; k++)
                if (we[k] && w_addr[k*ADDR_W +: ADDR_W] == a && live(a)) begin
                    d   = w_data[k*DATA_W +: DATA_W];
                    hit = 1'b1;
                end
            if (!live(a))
                d = '0;
        end
        assign r_data[i*DATA_W +: DATA_W] = rst ? d : '0;
        assign r_busy[i] = rst && busy[a] && !hit;
    end
endmodule
